// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU over a
// fixed busy period and commits the result on the final edge of that period.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        start,
    output logic [31:0] MD
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e      state_q;
    logic        busy_q;
    logic [3:0]  cnt_q;
    logic [3:0]  opl_q;
    logic [31:0] al_q;
    logic [31:0] bl_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_muldiv;
    logic        is_mul;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    assign is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign start     = en && is_muldiv && !busy_q;
    assign busy      = busy_q;

    always_comb begin
        MD = 32'd0;
        if (op == OP_MFHI) begin
            MD = hi_q;
        end else if (op == OP_MFLO) begin
            MD = lo_q;
        end
    end

    // Datapath on the latched operands; only sampled on the last edge of the busy period.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic        [31:0] bls_safe;
    logic        [31:0] blu_safe;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    assign prod_s = $signed({{32{al_q[31]}}, al_q}) * $signed({{32{bl_q[31]}}, bl_q});
    assign prod_u = {32'd0, al_q} * {32'd0, bl_q};

    assign div_zero = (bl_q == 32'd0);
    // INT_MIN / -1 overflows; dividing by 1 instead yields quotient INT_MIN, remainder 0.
    assign div_ovf  = (al_q == 32'h8000_0000) && (bl_q == 32'hFFFF_FFFF);
    assign bls_safe = (div_zero || div_ovf) ? 32'd1 : bl_q;
    assign blu_safe = div_zero ? 32'd1 : bl_q;

    assign quo_s = $signed(al_q) / $signed(bls_safe);
    assign rem_s = $signed(al_q) % $signed(bls_safe);
    assign quo_u = al_q / blu_safe;
    assign rem_u = al_q % blu_safe;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (opl_q)
            OP_MULT: begin
                hi_d = prod_s[63:32];
                lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
                hi_d = prod_u[63:32];
                lo_d = prod_u[31:0];
            end
            OP_DIV: begin
                if (!div_zero) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    hi_d = rem_u;
                    lo_d = quo_u;
                end
            end
            default: begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            opl_q   <= OP_NONE;
            al_q    <= 32'd0;
            bl_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        opl_q   <= op;
                        al_q    <= A;
                        bl_q    <= B;
                        cnt_q   <= is_mul ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else if (en && (op == OP_MTHI)) begin
                        hi_q <= A;
                    end else if (en && (op == OP_MTLO)) begin
                        lo_q <= A;
                    end
                end
                S_RUN: begin
                    if (cnt_q == 4'd0) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues expected MFHI/MFLO values and busy-period
// lengths; a negedge monitor pops and compares them as the DUT presents them.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        start;
    logic [31:0] MD;

    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4,
                           MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] md_q[$];
    int          blen_q[$];
    int          busy_run = 0;

    mdu dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .start (start),
        .MD    (MD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: an MFHI/MFLO cycle is a presented MD value; a busy fall closes a busy period.
    initial begin
        forever begin
            @(negedge clk);
            if (op == MFHI || op == MFLO) begin
                if (md_q.size() == 0) chk("md_unexpected", MD, 32'hDEAD_BEEF);
                else begin
                    logic [31:0] e;
                    e = md_q.pop_front();
                    chk(op == MFHI ? "mfhi" : "mflo", MD, e);
                    $display("read %s MD=0x%08h expected 0x%08h", op == MFHI ? "MFHI" : "MFLO", MD, e);
                end
            end
            if (busy === 1'b1) busy_run++;
            else if (busy_run > 0) begin
                if (blen_q.size() == 0) chk("busy_unexpected", busy_run, 0);
                else begin
                    int e;
                    e = blen_q.pop_front();
                    chk("busy_len", busy_run, e);
                    $display("busy period %0d cycles expected %0d", busy_run, e);
                end
                busy_run = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle instruction; start is checked at the negedge before the capturing edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic e, input logic start_exp);
        op = o; A = a; B = b; en = e;
        @(negedge clk);
        chk("start", start, start_exp);
        $display("issue op=%0d A=0x%08h B=0x%08h en=%0d start=%0d", o, a, b, e, start);
        step();
        op = NONE; A = 32'd0; B = 32'd0; en = 1'b1;
    endtask

    task automatic mf(input logic [3:0] o, input logic [31:0] exp);
        md_q.push_back(exp);
        op = o;
        step();
        op = NONE;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (busy === 1'b0) return;
            step();
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; op = NONE; A = 32'd0; B = 32'd0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        step();
        mf(MFHI, 32'd0);
        mf(MFLO, 32'd0);

        // Signed multiply: -3 * 5
        blen_q.push_back(5);
        issue(MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
        wait_idle();
        mf(MFLO, 32'hFFFF_FFF1);
        mf(MFHI, 32'hFFFF_FFFF);

        blen_q.push_back(5);
        issue(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1);
        wait_idle();
        mf(MFHI, 32'h0000_0001);
        mf(MFLO, 32'hFFFF_FFFE);

        // Signed divide: -7 / 2 truncates to -3, remainder -1
        blen_q.push_back(10);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        wait_idle();
        mf(MFLO, 32'hFFFF_FFFD);
        mf(MFHI, 32'hFFFF_FFFF);

        // Back-to-back: new start in the first idle cycle
        blen_q.push_back(10);
        issue(DIVU, 32'd7, 32'd2, 1'b1, 1'b1);
        wait_idle();
        blen_q.push_back(5);
        issue(MULTU, 32'd6, 32'd7, 1'b1, 1'b1);
        wait_idle();
        mf(MFLO, 32'd42);
        mf(MFHI, 32'd0);
        blen_q.push_back(10);
        issue(DIVU, 32'd7, 32'd2, 1'b1, 1'b1);
        wait_idle();
        mf(MFLO, 32'd3);
        mf(MFHI, 32'd1);

        // Divide by zero leaves HI/LO intact
        issue(MTHI, 32'h11, 32'd0, 1'b1, 1'b0);
        issue(MTLO, 32'h22, 32'd0, 1'b1, 1'b0);
        blen_q.push_back(10);
        issue(DIVU, 32'd7, 32'd0, 1'b1, 1'b1);
        wait_idle();
        mf(MFHI, 32'h11);
        mf(MFLO, 32'h22);

        // en gating
        issue(MULT, 32'd9, 32'd9, 1'b0, 1'b0);
        @(negedge clk);
        chk("en0_busy", busy, 1'b0);
        step();
        issue(MTLO, 32'h99, 32'd0, 1'b0, 1'b0);
        mf(MFHI, 32'h11);
        mf(MFLO, 32'h22);

        // Reset during the third busy cycle aborts the multiply
        blen_q.push_back(3);
        issue(MULT, 32'd3, 32'd3, 1'b1, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 1'b0);
        step();
        mf(MFHI, 32'd0);
        mf(MFLO, 32'd0);
        for (int i = 0; i < 8; i++) step();
        @(negedge clk);
        chk("rst_no_update_busy", busy, 1'b0);
        step();
        mf(MFLO, 32'd0);

        // Collision: MULT presented while DIV runs is dropped
        blen_q.push_back(10);
        issue(DIV, 32'd100, 32'd7, 1'b1, 1'b1);
        step();
        issue(MULT, 32'd5, 32'd6, 1'b1, 1'b0);
        wait_idle();
        mf(MFLO, 32'd14);
        mf(MFHI, 32'd2);

        for (int i = 0; i < 12; i++) step();
        chk("md_queue_drained", md_q.size(), 0);
        chk("busy_queue_drained", blen_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
